// File: rtl/alu_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: operation select codes,
// FSM states and the "is this an iterative op" helper.
// Honours ALU_DIV_EN: without it the divide code is not treated as iterative.
package alu_multiciclo_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_DIV = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_NOT = 4'h7;
  localparam logic [3:0] ALU_SLT = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Ops that take WIDTH iterations in CALC instead of finishing at accept.
  function automatic logic is_iter(input logic [3:0] s);
`ifdef ALU_DIV_EN
    return (s == ALU_MUL) || (s == ALU_DIV);
`else
    return (s == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_divisor.sv
// Iterative restoring divider, one quotient bit per step, WIDTH steps.
// Only compiled when ALU_DIV_EN is defined.
// quotient is the value the quotient register takes after the current
// step, so the parent can capture the final answer on the last step edge.
`ifdef ALU_DIV_EN
module alu_divisor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;

  // One restoring step: shift in next dividend bit, trial subtract.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = ~diff[WIDTH];
    rem_nxt  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient = {quo[WIDTH-2:0], ge};
  end

  // Partial remainder / quotient registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quotient;
    end
  end

endmodule
`endif

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt, WIDTH-step shift-add MUL
// and (with ALU_DIV_EN) WIDTH-step restoring DIV. start/busy/done handshake.
// Without ALU_DIV_EN the divide code is reported as illegal and
// div_by_zero stays 0.
module alu_multiciclo
  import alu_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal_op,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             accept, iterate, last;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [WIDTH-1:0] simple_res, iter_res;
  logic             simple_ill;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    iterate   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = is_iter(sel) ? CALC : FIN;
      end
      CALC: begin
        iterate = 1'b1;
        if (count == CW'(1)) begin
          last      = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // Single-cycle ops, evaluated directly on the live operands at accept.
  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    case (sel)
      ALU_ADD: simple_res = a + b;
      ALU_SUB: simple_res = a - b;
      ALU_AND: simple_res = a & b;
      ALU_OR:  simple_res = a | b;
      ALU_XOR: simple_res = a ^ b;
      ALU_NOT: simple_res = ~a;
      ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: simple_ill = 1'b1;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_DIV_EN
  logic [3:0]       op;
  logic             b_zero;
  logic [WIDTH-1:0] div_q;

  alu_divisor #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && (sel == ALU_DIV)),
    .step     (iterate && (op == ALU_DIV)),
    .dividend (a),
    .divisor  (b),
    .quotient (div_q)
  );

  // Remember which iterative op is running and whether it divides by zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      b_zero <= 1'b0;
    end else if (accept) begin
      op     <= sel;
      b_zero <= (b == '0);
    end
  end

  assign iter_res = (op == ALU_DIV) ? (b_zero ? '1 : div_q) : acc_nxt;

  // Divide-by-zero flag: cleared on accept, raised when a DIV by 0 completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       div_by_zero <= 1'b0;
    else if (accept)  div_by_zero <= 1'b0;
    else if (last)    div_by_zero <= (op == ALU_DIV) && b_zero;
  end
`else
  assign iter_res    = acc_nxt;
  assign div_by_zero = 1'b0;
`endif

  // Datapath: operand capture, multiplier iterations and result/flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept) begin
      count      <= CW'(WIDTH);
      mcand      <= a;
      mplier     <= b;
      acc        <= '0;
      illegal_op <= 1'b0;
      if (!is_iter(sel)) begin
        result     <= simple_res;
        zero       <= (simple_res == '0);
        illegal_op <= simple_ill;
      end
    end else if (iterate) begin
      count  <= count - CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) begin
        result <= iter_res;
        zero   <= (iter_res == '0);
      end
    end
  end

endmodule
